// File: rtl/recovery_pin_conditioner.sv
// Recovery pin front end: synchronizes the raw pos/neg pins, rejects short glitches,
// flags a stuck-equal differential pair and counts rejected glitches.

package common_p;
    typedef struct packed {
        logic clk;
        logic srst;
    } clk_dom_s;
endpackage

package clks_alot_p;
    typedef struct packed {
        logic pos;
        logic neg;
    } recovery_pins_s;
endpackage

module recovery_pin_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  common_p::clk_dom_s          sys_dom_i,
    input  logic                        conditioner_en_i,
    input  logic [FILTER_W-1:0]         filter_len_i,
    input  logic                        diff_check_en_i,
    input  logic [FILTER_W-1:0]         fault_limit_i,
    input  logic                        fault_clear_i,
    input  logic                        raw_pos_i,
    input  logic                        raw_neg_i,
    output clks_alot_p::recovery_pins_s io_clk_o,
    output logic                        diff_fault_o,
    output logic [7:0]                  glitch_count_o
);
    localparam logic [FILTER_W-1:0] CNT_ZERO = {FILTER_W{1'b0}};
    localparam logic [FILTER_W-1:0] CNT_ONE  = {{(FILTER_W-1){1'b0}}, 1'b1};
    localparam logic [FILTER_W-1:0] CNT_MAX  = {FILTER_W{1'b1}};

    logic clk;
    logic srst;
    assign clk  = sys_dom_i.clk;
    assign srst = sys_dom_i.srst;

    logic [SYNC_STAGES-1:0] sync_pos_r;
    logic [SYNC_STAGES-1:0] sync_neg_r;
    // Index 0 is the pos pin, index 1 is the neg pin throughout.
    logic [1:0]             sync_s;
    logic [1:0]             filt_r;
    logic [1:0]             filt_nxt_s;
    logic [1:0]             accept_s;
    logic [1:0]             reject_s;
    logic [FILTER_W-1:0]    cnt_r     [2];
    logic [FILTER_W-1:0]    cnt_nxt_s [2];
    logic [8:0]             glitch_sum_s;
    logic [7:0]             glitch_nxt_s;
    logic [7:0]             glitch_r;
    logic [FILTER_W-1:0]    fcnt_r;
    logic [FILTER_W-1:0]    fcnt_nxt_s;
    logic [1:0]             seen_r;
    logic [1:0]             seen_nxt_s;
    logic                   armed_r;
    logic                   armed_nxt_s;
    logic                   fault_r;
    logic                   fault_nxt_s;
    logic                   pins_equal_s;

    assign sync_s       = {sync_neg_r[SYNC_STAGES-1], sync_pos_r[SYNC_STAGES-1]};
    assign pins_equal_s = (filt_r[0] == filt_r[1]);

    // Per-pin stability filter: accept a level only after it has persisted long enough.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_nxt_s[i] = filt_r[i];
            cnt_nxt_s[i]  = CNT_ZERO;
            accept_s[i]   = 1'b0;
            reject_s[i]   = 1'b0;
            if (conditioner_en_i) begin
                if (sync_s[i] == filt_r[i]) begin
                    reject_s[i] = (cnt_r[i] != CNT_ZERO);
                end else if (cnt_r[i] >= filter_len_i) begin
                    filt_nxt_s[i] = sync_s[i];
                    accept_s[i]   = 1'b1;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_nxt_s[i] = CNT_ZERO;
            end
        end
    end

    // Saturating glitch counter; both pins may reject on the same edge.
    always_comb begin
        glitch_sum_s = {1'b0, glitch_r} + {8'd0, reject_s[0]} + {8'd0, reject_s[1]};
        if (glitch_sum_s > 9'd255) begin
            glitch_nxt_s = 8'hFF;
        end else begin
            glitch_nxt_s = glitch_sum_s[7:0];
        end
    end

    // Differential checker: only armed once both pins have proven they can move.
    always_comb begin
        fcnt_nxt_s  = fcnt_r;
        seen_nxt_s  = seen_r;
        armed_nxt_s = armed_r;
        fault_nxt_s = fault_r;
        if (fault_clear_i) begin
            fcnt_nxt_s  = CNT_ZERO;
            seen_nxt_s  = 2'b00;
            armed_nxt_s = 1'b0;
            fault_nxt_s = 1'b0;
        end else if (conditioner_en_i && diff_check_en_i) begin
            seen_nxt_s  = seen_r | accept_s;
            armed_nxt_s = armed_r | (&seen_nxt_s);
            if (armed_r && pins_equal_s) begin
                if (fcnt_r != CNT_MAX) begin
                    fcnt_nxt_s = fcnt_r + CNT_ONE;
                end else begin
                    fcnt_nxt_s = fcnt_r;
                end
                if (fcnt_r >= fault_limit_i) begin
                    fault_nxt_s = 1'b1;
                end else begin
                    fault_nxt_s = fault_r;
                end
            end else begin
                fcnt_nxt_s = CNT_ZERO;
            end
        end else begin
            fcnt_nxt_s = CNT_ZERO;
        end
    end

    // State registers; the synchronizers run whenever out of reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_pos_r <= {SYNC_STAGES{1'b0}};
            sync_neg_r <= {SYNC_STAGES{1'b0}};
            filt_r     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            glitch_r   <= 8'd0;
            fcnt_r     <= CNT_ZERO;
            seen_r     <= 2'b00;
            armed_r    <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            sync_pos_r <= {sync_pos_r[SYNC_STAGES-2:0], raw_pos_i};
            sync_neg_r <= {sync_neg_r[SYNC_STAGES-2:0], raw_neg_i};
            filt_r     <= filt_nxt_s;
            for (int i = 0; i < 2; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            glitch_r   <= glitch_nxt_s;
            fcnt_r     <= fcnt_nxt_s;
            seen_r     <= seen_nxt_s;
            armed_r    <= armed_nxt_s;
            fault_r    <= fault_nxt_s;
        end
    end

    assign io_clk_o.pos   = filt_r[0];
    assign io_clk_o.neg   = filt_r[1];
    assign diff_fault_o   = fault_r;
    assign glitch_count_o = glitch_r;

endmodule

// File: tb/tb_recovery_pin_conditioner.sv
// Bench for recovery_pin_conditioner: vector table plus hand sequences, checked through
// an expectation queue that is filled when stimulus is driven and drained after each edge.
`timescale 1ns/1ps

module tb_recovery_pin_conditioner;
    import common_p::*;
    import clks_alot_p::*;

    logic           clk = 1'b0;
    logic           srst = 1'b1;
    logic           en = 1'b0;
    logic [3:0]     len = 4'd0;
    logic           dce = 1'b0;
    logic [3:0]     lim = 4'd0;
    logic           fclr = 1'b0;
    logic           rp = 1'b0;
    logic           rn = 1'b0;
    clk_dom_s       dom;
    recovery_pins_s pins;
    logic           fault;
    logic [7:0]     gcount;

    int total = 0;
    int bad = 0;

    assign dom.clk  = clk;
    assign dom.srst = srst;

    always #5 clk = ~clk;

    recovery_pin_conditioner #(.SYNC_STAGES(2), .FILTER_W(4)) dut (
        .sys_dom_i        (dom),
        .conditioner_en_i (en),
        .filter_len_i     (len),
        .diff_check_en_i  (dce),
        .fault_limit_i    (lim),
        .fault_clear_i    (fclr),
        .raw_pos_i        (rp),
        .raw_neg_i        (rn),
        .io_clk_o         (pins),
        .diff_fault_o     (fault),
        .glitch_count_o   (gcount)
    );

    typedef struct {
        logic       srst, en, dce, fclr, rp, rn, chk;
        logic [3:0] len, lim;
        logic       ep, eneg, ef;
        logic [7:0] egc;
    } vec_t;

    typedef struct {
        logic       chk, ep, eneg, ef;
        logic [7:0] egc;
        int         tag;
    } exp_t;

    exp_t exp_q[$];

    function automatic vec_t mk(input logic s, input logic e, input logic [3:0] l,
                                input logic d, input logic [3:0] lm, input logic fc,
                                input logic p, input logic n, input logic ck,
                                input logic xp, input logic xn, input logic xf,
                                input logic [7:0] xg);
        vec_t v;
        v.srst = s;  v.en = e;   v.len = l;   v.dce = d;  v.lim = lm; v.fclr = fc;
        v.rp = p;    v.rn = n;   v.chk = ck;  v.ep = xp;  v.eneg = xn;
        v.ef = xf;   v.egc = xg;
        return v;
    endfunction

    // Plain filtering vector: enabled, no differential check.
    function automatic vec_t fv(input logic [3:0] l, input logic p, input logic n,
                                input logic xp, input logic xn, input logic [7:0] xg);
        return mk(1'b0, 1'b1, l, 1'b0, 4'd0, 1'b0, p, n, 1'b1, xp, xn, 1'b0, xg);
    endfunction

    task automatic step(input vec_t v, input int tag);
        exp_t e;
        @(negedge clk);
        srst = v.srst; en = v.en; len = v.len; dce = v.dce; lim = v.lim;
        fclr = v.fclr; rp = v.rp; rn = v.rn;
        e.chk = v.chk; e.ep = v.ep; e.eneg = v.eneg; e.ef = v.ef; e.egc = v.egc;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Scoreboard: each expectation belongs to the edge that follows its stimulus.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                total++;
                if (pins.pos !== e.ep || pins.neg !== e.eneg || fault !== e.ef ||
                    gcount !== e.egc) begin
                    bad++;
                    $display("FAIL vec %0d: got pos=%b neg=%b fault=%b glitches=%0d, want pos=%b neg=%b fault=%b glitches=%0d",
                             e.tag, pins.pos, pins.neg, fault, gcount,
                             e.ep, e.eneg, e.ef, e.egc);
                end
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : test
        vec_t tbl[$];
        logic hp[33];
        logic hn[33];
        logic xp, xn, p, n, f;
        int   gexp;

        // Reset.
        tbl.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(mk(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        // len=3: 2-wide pos glitch, 2-wide glitch on both pins, then a held rise.
        tbl.push_back(fv(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(fv(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(fv(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(fv(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
        tbl.push_back(fv(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(fv(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(fv(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
        tbl.push_back(fv(4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1));
        tbl.push_back(fv(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(fv(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
        tbl.push_back(fv(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
        for (int i = 0; i < 5; i++) tbl.push_back(fv(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3));
        tbl.push_back(fv(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3));
        tbl.push_back(fv(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3));
        // len=0: 1-cycle neg pulse passes straight through, 2 edges behind the capture edge.
        tbl.push_back(fv(4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3));
        tbl.push_back(fv(4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3));
        tbl.push_back(fv(4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3));
        tbl.push_back(fv(4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3));
        tbl.push_back(fv(4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3));
        // Disabled while the pins toggle: outputs and count hold.
        for (int i = 0; i < 20; i++) begin
            tbl.push_back(mk(1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 1'b0, 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0, 8'd3));
        end
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mk(1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3));
        end
        // Re-enabled at len=1: pos falls, neg rises, then a rejected 1-cycle pos pulse.
        tbl.push_back(fv(4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3));
        tbl.push_back(fv(4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3));
        tbl.push_back(fv(4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1000 + i);

        // Differential fault, len=0, limit=2: clear, toggle, hold equal, clear, re-arm.
        for (int i = 0; i < 33; i++) begin
            if (i == 0)                 begin p = 1'b0; n = 1'b1; end
            else if (i <= 3)            begin p = 1'b1; n = 1'b0; end
            else if (i <= 6)            begin p = 1'b0; n = 1'b1; end
            else if (i <= 19)           begin p = 1'b1; n = 1'b1; end
            else if (i <= 22)           begin p = 1'b0; n = 1'b1; end
            else if (i <= 25)           begin p = 1'b1; n = 1'b0; end
            else                        begin p = 1'b1; n = 1'b1; end
            hp[i] = p;
            hn[i] = n;
            if (i < 2) begin xp = 1'b0; xn = 1'b1; end
            else       begin xp = hp[i-2]; xn = hn[i-2]; end
            f = ((i >= 12) && (i <= 13)) || (i >= 31);
            step(mk(1'b0, 1'b1, 4'd0, 1'b1, 4'd2, 1'(i == 0 || i == 14), p, n, 1'b1,
                    xp, xn, f, 8'd4), 2000 + i);
        end

        // 300 rejected 2-cycle low pulses on pos at len=3: count saturates at 255.
        gexp = 4;
        for (int k = 0; k < 300; k++) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 4 && gexp < 255) gexp = gexp + 1;
                step(mk(1'b0, 1'b1, 4'd3, 1'b0, 4'd2, 1'b0, 1'(c >= 2), 1'b1, 1'b1,
                        1'b1, 1'b1, 1'b1, 8'(gexp)), 3000 + k);
            end
        end

        // Reset with pos mid-filter and the fault set; the pending level must be lost.
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b0, 1'b1, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 8'd255), 4000 + i);
        end
        step(mk(1'b1, 1'b1, 4'd3, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1,
                1'b0, 1'b0, 1'b0, 8'd0), 4004);
        for (int i = 5; i < 12; i++) begin
            step(mk(1'b0, 1'b1, 4'd3, 1'b0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1,
                    1'(i >= 10), 1'(i >= 10), 1'b0, 8'd0), 4000 + i);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recovery_pin_conditioner.md
Name: recovery_pin_conditioner

Overview:
- Front-end stage directly upstream of event recovery.
- Takes the raw, asynchronous pos/neg recovery pins, synchronizes them into the system domain, rejects glitches shorter than a programmable length, and drives a clks_alot_p::recovery_pins_s bundle that the event-recovery stage consumes with zero added delay.
- Also flags differential faults (pos and neg stuck equal) and counts rejected glitches for debug.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per pin; legal minimum is 2.
- FILTER_W, 4, width of filter_len_i, fault_limit_i and the internal stability/fault counters.

Ports:
- sys_dom_i  input  common_p::clk_dom_s  one clock and one synchronous, active-high reset, carried as sys_dom_i.clk and sys_dom_i.srst; all logic runs on this single clock.
- conditioner_en_i  input  1  filter/fault enable.
- filter_len_i  input  FILTER_W  stability length; 0 means no filtering.
- diff_check_en_i  input  1  enables the differential fault check.
- fault_limit_i  input  FILTER_W  number of consecutive equal cycles tolerated before a fault.
- fault_clear_i  input  1  clears diff_fault_o and disarms the checker.
- raw_pos_i  input  1  asynchronous pin.
- raw_neg_i  input  1  asynchronous pin.
- io_clk_o  output  clks_alot_p::recovery_pins_s  filtered pins (.pos, .neg).
- diff_fault_o  output  1  sticky differential fault.
- glitch_count_o  output  8  saturating count of rejected transitions.

Behaviour:
- Reset (srst=1 at an edge): all synchronizer flops = 0, io_clk_o.pos/.neg = 0, stability counters = 0, fault counter = 0, armed = 0, diff_fault_o = 0, glitch_count_o = 0.
- Synchronizer: per pin, an SYNC_STAGES-deep flop chain. It runs whenever not in reset, regardless of enable. sync_x is the last stage.
- Filter, per pin x, evaluated only when conditioner_en_i=1. Exactly one rule applies per edge, in this priority:
  - sync_x == filt_x: cnt_x <= 0. If cnt_x != 0 this is a rejected glitch and glitch_count_o increments.
  - sync_x != filt_x and cnt_x >= filter_len_i: filt_x <= sync_x, cnt_x <= 0.
  - Otherwise: cnt_x <= cnt_x + 1.
- Filter latency: a new level on sync_x is accepted only after it differs from filt_x for filter_len_i+1 consecutive edges. Raw-pin-to-io_clk_o latency is SYNC_STAGES + filter_len_i + 1 edges. With filter_len_i=0 this is SYNC_STAGES+1.
- filter_len_i may change at any time. The >= compare means a reduced length accepts a pending level on the next edge.
- conditioner_en_i=0:
  - filt_x and io_clk_o hold their values.
  - cnt_x is forced to 0, with no glitch count.
  - The fault counter is held at 0 and armed holds.
  - diff_fault_o holds.
- glitch_count_o:
  - Increments by the number of pins rejecting a glitch on that edge, which is 0, 1 or 2.
  - Saturates at 255.
  - Cleared only by reset.
- Differential check, active when conditioner_en_i=1 and diff_check_en_i=1:
  - armed sets once each pin has had at least one accepted filt_x transition since reset or fault_clear_i.
  - While armed and filt_pos == filt_neg: fcnt <= fcnt+1, saturating at all-ones.
  - If armed, equal, and fcnt >= fault_limit_i: diff_fault_o <= 1 (sticky).
  - When not equal: fcnt <= 0.
  - With diff_check_en_i=0: fcnt <= 0, and diff_fault_o holds.
- fault_clear_i=1: diff_fault_o <= 0, fcnt <= 0, armed <= 0. Clear wins over a set on the same edge.
- io_clk_o is driven straight from filt_pos and filt_neg registers; there is no combinational path from the raw pins.

Test Plan:
- SYNC_STAGES=2, filter_len_i=3, raw_pos 0->1 held -> io_clk_o.pos rises exactly 6 edges after the capturing edge; glitch_count_o stays 0.
- filter_len_i=3, raw_pos high-pulse 2 cycles wide -> io_clk_o.pos stays 0; glitch_count_o = 1. Repeat the same glitch on both pins in the same cycle -> count increases by 2.
- filter_len_i=0, 1-cycle raw pulse -> io_clk_o.pos shows a 1-cycle pulse 3 edges later. 300 rejected glitches at filter_len_i=3 -> glitch_count_o saturates at 255.
- diff_check_en_i=1, fault_limit_i=2, clean complementary toggling on pos/neg then both held at 1 -> diff_fault_o asserts on the 3rd equal edge. fault_clear_i pulse -> deasserts and stays low until both pins toggle again.
- Assert srst mid-filter (cnt_pos=2) and with diff_fault_o=1 -> next edge: all outputs 0, glitch_count_o=0, and the pending level is discarded.
- conditioner_en_i=0 while raw pins toggle for 20 cycles -> io_clk_o holds and glitch_count_o is unchanged. Re-enable with filter_len_i=1 -> io_clk_o tracks the pins with latency SYNC_STAGES+2.
